// File: rtl/stall_ctrl_pkg.sv
// Shared widths, MDU latencies and hazard helpers for the pipeline stall controller.
package stall_ctrl_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned TUSE_W      = 2;
    localparam int unsigned TNEW_W      = 2;
    localparam int unsigned MD_CNT_W    = 4;
    localparam int unsigned STALL_CNT_W = 32;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    typedef logic [REG_W-1:0]       reg_idx_t;
    typedef logic [TUSE_W-1:0]      tuse_t;
    typedef logic [TNEW_W-1:0]      tnew_t;
    typedef logic [MD_CNT_W-1:0]    md_cnt_t;
    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

    typedef enum logic {
        MD_OP_MUL = 1'b0,
        MD_OP_DIV = 1'b1
    } md_op_e;

    // Destination-side view of an in-flight instruction in E or M.
    typedef struct packed {
        reg_idx_t a3;
        tnew_t    tnew;
        logic     wegrf;
    } producer_t;

    // RAW hazard: a live, nonzero source whose value is not yet forwardable in time.
    function automatic logic raw_hazard(input reg_idx_t src, input tuse_t tuse,
                                        input producer_t p);
        return (src != '0) && p.wegrf && (p.a3 == src) && (tuse < p.tnew);
    endfunction

    function automatic md_cnt_t md_latency(input md_op_e op);
        md_cnt_t lat;
        lat = (op == MD_OP_DIV) ? md_cnt_t'(DIV_CYCLES) : md_cnt_t'(MULT_CYCLES);
        return lat;
    endfunction

endpackage

// File: rtl/stall_ctrl_md_busy_timer.sv
// MDU busy countdown: loads the op latency on an uncancelled start, then counts to zero.
module md_busy_timer
    import stall_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    start,
    input  logic    div,
    input  logic    req,
    output logic    busy,
    output md_cnt_t cnt
);

    md_op_e op;

    always_comb begin
        op   = md_op_e'(div);
        busy = start || (cnt != '0);
    end

    // A new start discards any countdown in flight; req only cancels the starting op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start && !req) begin
            cnt <= md_latency(op);
        end else if (cnt != '0) begin
            cnt <= cnt - md_cnt_t'(1);
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: RAW, MDU-busy and eret/mtc0 interlocks plus a stall-cycle counter.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter stall_cnt_t STALL_CNT_INIT = '0  // reset value of the stall counter
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [REG_W-1:0]       D_A1,
    input  logic [REG_W-1:0]       D_A2,
    input  logic [TUSE_W-1:0]      D_Tuse_rs,
    input  logic [TUSE_W-1:0]      D_Tuse_rt,
    input  logic [REG_W-1:0]       E_A3,
    input  logic [REG_W-1:0]       M_A3,
    input  logic [TNEW_W-1:0]      E_Tnew,
    input  logic [TNEW_W-1:0]      M_Tnew,
    input  logic                   E_Wegrf,
    input  logic                   M_Wegrf,
    input  logic                   D_is_md,
    input  logic                   E_md_start,
    input  logic                   E_md_div,
    input  logic                   D_eret,
    input  logic                   E_mtc0,
    input  logic                   M_mtc0,
    output logic                   F_en,
    output logic                   D_en,
    output logic                   E_clr,
    output logic                   md_busy,
    output logic [MD_CNT_W-1:0]    md_cnt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    producer_t e_prod;
    producer_t m_prod;
    logic      stall_rs;
    logic      stall_rt;
    logic      stall_md;
    logic      stall_eret;
    logic      stall;

    md_busy_timer u_md_busy_timer (
        .clk   (clk),
        .reset (reset),
        .start (E_md_start),
        .div   (E_md_div),
        .req   (req),
        .busy  (md_busy),
        .cnt   (md_cnt)
    );

    always_comb begin
        e_prod     = '{a3: E_A3, tnew: E_Tnew, wegrf: E_Wegrf};
        m_prod     = '{a3: M_A3, tnew: M_Tnew, wegrf: M_Wegrf};
        stall_rs   = raw_hazard(D_A1, D_Tuse_rs, e_prod) || raw_hazard(D_A1, D_Tuse_rs, m_prod);
        stall_rt   = raw_hazard(D_A2, D_Tuse_rt, e_prod) || raw_hazard(D_A2, D_Tuse_rt, m_prod);
        stall_md   = D_is_md && md_busy;
        stall_eret = D_eret && (E_mtc0 || M_mtc0);
        // A flush outranks every interlock: the stalled instruction is being discarded.
        stall      = (stall_rs || stall_rt || stall_md || stall_eret) && !req;
        F_en       = !stall;
        D_en       = !stall;
        E_clr      = stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= STALL_CNT_INIT;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + stall_cnt_t'(1);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl; a second instance starts its counter near saturation.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [4:0]  D_A1, D_A2, E_A3, M_A3;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
    logic        E_Wegrf, M_Wegrf, D_is_md, E_md_start, E_md_div;
    logic        D_eret, E_mtc0, M_mtc0;
    logic        F_en, D_en, E_clr, md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt;
    logic        s_F_en, s_D_en, s_E_clr, s_md_busy;
    logic [3:0]  s_md_cnt;
    logic [31:0] s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_ctrl dut (
        .clk(clk), .reset(reset), .req(req),
        .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .E_Wegrf(E_Wegrf), .M_Wegrf(M_Wegrf), .D_is_md(D_is_md),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .D_eret(D_eret), .E_mtc0(E_mtc0), .M_mtc0(M_mtc0),
        .F_en(F_en), .D_en(D_en), .E_clr(E_clr), .md_busy(md_busy),
        .md_cnt(md_cnt), .stall_cnt(stall_cnt)
    );

    stall_ctrl #(.STALL_CNT_INIT(32'hFFFF_FFFE)) dut_sat (
        .clk(clk), .reset(reset), .req(req),
        .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .E_A3(E_A3), .M_A3(M_A3), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew),
        .E_Wegrf(E_Wegrf), .M_Wegrf(M_Wegrf), .D_is_md(D_is_md),
        .E_md_start(E_md_start), .E_md_div(E_md_div),
        .D_eret(D_eret), .E_mtc0(E_mtc0), .M_mtc0(M_mtc0),
        .F_en(s_F_en), .D_en(s_D_en), .E_clr(s_E_clr), .md_busy(s_md_busy),
        .md_cnt(s_md_cnt), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp_stall);
        check({tag, "_F_en"}, {31'd0, F_en}, {31'd0, !exp_stall});
        check({tag, "_D_en"}, {31'd0, D_en}, {31'd0, !exp_stall});
        check({tag, "_E_clr"}, {31'd0, E_clr}, {31'd0, exp_stall});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = 0; D_A1 = 0; D_A2 = 0; D_Tuse_rs = 0; D_Tuse_rt = 0;
        E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0; E_Wegrf = 0; M_Wegrf = 0;
        D_is_md = 0; E_md_start = 0; E_md_div = 0; D_eret = 0; E_mtc0 = 0; M_mtc0 = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        #2;
        check_stall("rst", 0);
        check("rst_md_busy", {31'd0, md_busy}, 0);
        check("rst_md_cnt", {28'd0, md_cnt}, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_sat_cnt", s_stall_cnt, 32'hFFFF_FFFE);
        tick();
        reset = 0;

        // RAW hazard on rs through E
        E_A3 = 5; E_Wegrf = 1; E_Tnew = 2; D_A1 = 5; D_Tuse_rs = 0;
        #1 check_stall("raw_e_rs", 1);
        tick();
        check("raw_e_cnt", stall_cnt, 1);
        check("sat_1", s_stall_cnt, 32'hFFFF_FFFF);
        D_A1 = 0;
        #1 check_stall("raw_r0", 0);
        D_A1 = 5; D_Tuse_rs = 2;
        #1 check_stall("raw_tuse_eq", 0);
        clear_inputs();

        // RAW hazard on rt through M
        M_A3 = 7; M_Wegrf = 1; M_Tnew = 1; D_A2 = 7; D_Tuse_rt = 0;
        #1 check_stall("raw_m_rt", 1);
        tick();
        check("raw_m_cnt", stall_cnt, 2);
        check("sat_2", s_stall_cnt, 32'hFFFF_FFFF);
        M_Wegrf = 0;
        #1 check_stall("raw_m_nowe", 0);
        clear_inputs();

        // divide: busy on start, then 10..1 stalls a dependent MDU op
        E_md_start = 1; E_md_div = 1;
        #1 check("div_start_busy", {31'd0, md_busy}, 1);
        check("div_start_cnt", {28'd0, md_cnt}, 0);
        tick();
        E_md_start = 0; E_md_div = 0; D_is_md = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("div_cnt", {28'd0, md_cnt}, 32'(10 - i));
            check("div_stall", {31'd0, E_clr}, 1);
            tick();
        end
        check("div_done_cnt", {28'd0, md_cnt}, 0);
        check("div_done_busy", {31'd0, md_busy}, 0);
        check_stall("div_done", 0);
        check("div_stall_cnt", stall_cnt, 12);
        check("sat_hold", s_stall_cnt, 32'hFFFF_FFFF);
        clear_inputs();

        // multiply, then reload with a divide mid-countdown, then req mid-operation
        E_md_start = 1;
        tick();
        E_md_start = 0;
        check("mul_cnt5", {28'd0, md_cnt}, 5);
        tick();
        check("mul_cnt4", {28'd0, md_cnt}, 4);
        E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0; E_md_div = 0;
        check("reload_cnt", {28'd0, md_cnt}, 10);
        req = 1;
        tick();
        req = 0;
        check("req_mid_cnt", {28'd0, md_cnt}, 9);
        repeat (9) tick();
        check("mul_end_cnt", {28'd0, md_cnt}, 0);

        // start cancelled by req in the same cycle
        E_md_start = 1; E_md_div = 1; req = 1; D_is_md = 1;
        E_A3 = 5; E_Wegrf = 1; E_Tnew = 2; D_A1 = 5;
        #1 check_stall("req_cancel", 0);
        tick();
        check("req_cancel_cnt", {28'd0, md_cnt}, 0);
        check("req_cancel_sc", stall_cnt, 12);
        clear_inputs();

        // eret waits for an mtc0 in M, then proceeds
        D_eret = 1; M_mtc0 = 1;
        #1 check_stall("eret_m", 1);
        tick();
        M_mtc0 = 0;
        #1 check_stall("eret_go", 0);
        check("eret_cnt", stall_cnt, 13);
        E_mtc0 = 1;
        #1 check_stall("eret_e", 1);
        clear_inputs();

        // asynchronous reset mid-divide
        E_md_start = 1; E_md_div = 1;
        tick();
        E_md_start = 0; E_md_div = 0;
        repeat (4) tick();
        check("pre_rst_cnt", {28'd0, md_cnt}, 6);
        #1 reset = 1;
        #1;
        check("async_rst_cnt", {28'd0, md_cnt}, 0);
        check("async_rst_busy", {31'd0, md_busy}, 0);
        check("async_rst_sc", stall_cnt, 0);
        tick();
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port req  input  1  exception/interrupt request; flushes the pipeline this cycle.
REQ-004 SHALL have ports D_A1, D_A2  input  5 each  rs/rt register numbers read by the instruction in D.
REQ-005 SHALL have ports D_Tuse_rs, D_Tuse_rt  input  2 each  cycles until D instruction consumes rs/rt.
REQ-006 SHALL have ports E_A3, M_A3  input  5 each  destination register of the E/M instruction.
REQ-007 SHALL have ports E_Tnew, M_Tnew  input  2 each  cycles until the E/M result is forwardable.
REQ-008 SHALL have ports E_Wegrf, M_Wegrf  input  1 each  E/M instruction writes the GPR file.
REQ-009 SHALL have port D_is_md  input  1  D instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have ports E_md_start, E_md_div  input  1 each  E starts an MDU op; 1 = divide, 0 = multiply.
REQ-011 SHALL have ports D_eret, E_mtc0, M_mtc0  input  1 each  eret in D; mtc0 in E/M.
REQ-012 SHALL have ports F_en, D_en  output  1 each  enables for PC and F/D register.
REQ-013 SHALL have port E_clr  output  1  drives the clr input of the D/E register (inserts a bubble).
REQ-014 SHALL have ports md_busy (1), md_cnt (4), stall_cnt (32)  outputs  MDU busy flag, remaining cycles, total stall cycles.

Function
REQ-015 SHALL compute stall_rs = (D_A1!=0) & E_Wegrf & (E_A3==D_A1) & (D_Tuse_rs<E_Tnew), OR the same term with M_A3/M_Wegrf/M_Tnew.
REQ-016 SHALL compute stall_rt identically, using D_A2 and D_Tuse_rt.
REQ-017 SHALL compute stall_md = D_is_md & md_busy.
REQ-018 SHALL compute stall_eret = D_eret & (E_mtc0 | M_mtc0).
REQ-019 SHALL compute stall = (stall_rs|stall_rt|stall_md|stall_eret) & ~req.
REQ-020 SHALL drive F_en = D_en = ~stall and E_clr = stall, combinationally in the same cycle.
REQ-021 SHALL drive md_busy = E_md_start | (md_cnt!=0).
REQ-022 SHALL load md_cnt with 5 (multiply) or 10 (divide) on posedge when E_md_start & ~req.
REQ-023 SHALL otherwise decrement md_cnt by 1 per cycle while it is nonzero, and hold it at 0.
REQ-024 SHALL suppress the load when E_md_start & req are high in the same cycle; the E instruction is cancelled.
REQ-025 SHALL let a countdown already in progress continue to 0 when req asserts mid-operation.
REQ-026 SHALL reload md_cnt and discard the old countdown when E_md_start arrives while md_cnt!=0.
REQ-027 SHALL increment stall_cnt by 1 in every cycle where stall=1; it saturates at 32'hFFFF_FFFF and does not wrap.

Reset
REQ-028 SHALL asynchronously clear md_cnt=0 and stall_cnt=0 while reset=1, giving md_busy=0.
REQ-029 SHALL drive F_en=1, D_en=1, E_clr=0 during reset when all data inputs are 0.
REQ-030 SHALL begin normal operation on the first posedge after reset deasserts.

Structure
REQ-031 SHALL take MULT_CYCLES=5, DIV_CYCLES=10 and the Tuse/Tnew widths from the shared macro.v package.
REQ-032 SHALL place the MDU countdown (REQ-021..026) in one sub-module, md_busy_timer.
REQ-033 SHALL keep the hazard comparison logic purely combinational in the top level.

Verification
REQ-034 SHALL cover this scenario: E_A3=5, E_Wegrf=1, E_Tnew=2, D_A1=5, D_Tuse_rs=0 -> F_en=0, D_en=0, E_clr=1; with D_A1=0 -> no stall.
REQ-035 SHALL cover this scenario: E_md_start=1, E_md_div=1 -> md_cnt=10 next cycle, then 9..0; D_is_md=1 stalls for 10 cycles; stall_cnt increments by 10.
REQ-036 SHALL cover this scenario: E_md_start=1 and req=1 in the same cycle -> md_cnt stays 0; stall forced 0 that cycle.
REQ-037 SHALL cover this scenario: D_eret=1, M_mtc0=1 -> one stall cycle; the next cycle with E_mtc0=M_mtc0=0 -> F_en=1.
REQ-038 SHALL cover this scenario: stall_cnt preloaded to 32'hFFFF_FFFE, then 3 stall cycles -> holds at 32'hFFFF_FFFF.
REQ-039 SHALL cover this scenario: reset asserted mid-divide with md_cnt=6 -> md_cnt=0 and md_busy=0 immediately, without waiting for a clock edge.
